// File: rtl/pool_fc_stream.sv
// pool_fc_stream: 2x2 max/avg pooling of streamed windows into a feature
// buffer, followed by a sequential fully-connected MAC against an external
// weight memory. Class scores are held with a sticky done flag.
module pool_fc_stream #(
    parameter int unsigned DW      = 69,
    parameter int unsigned CH      = 8,
    parameter int unsigned POOL_X  = 12,
    parameter int unsigned POOL_Y  = 12,
    parameter int unsigned CLASSES = 10,
    parameter int unsigned WW      = 32,
    parameter int unsigned ACC_W   = 113,
    localparam int unsigned N      = CH * POOL_X * POOL_Y,
    localparam int unsigned AW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pool_mode,
    input  logic                     win_valid,
    output logic                     win_ready,
    input  logic [CH*4*DW-1:0]       win_data,
    output logic                     w_rd,
    output logic [AW-1:0]            w_addr,
    input  logic [CLASSES*WW-1:0]    w_data,
    output logic [CLASSES*ACC_W-1:0] prob,
    output logic                     fc_done
);

    localparam int unsigned PXY = POOL_X * POOL_Y;
    localparam int unsigned PW  = (PXY > 1) ? $clog2(PXY) : 1;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FC   = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            pos_q, pos_d;
    logic                     w_rd_q, w_rd_d;
    logic [AW-1:0]            w_addr_q, w_addr_d;
    logic                     win_ready_q, win_ready_d;
    logic                     fc_done_q, fc_done_d;
    logic [CLASSES*ACC_W-1:0] prob_q, prob_d;
    logic                     mac_en_q;
    logic [AW-1:0]            mac_idx_q;
    logic                     xfer;
    logic                     pos_last;
    logic                     mac_last;
    logic                     clr_prob;
    logic signed [DW-1:0]     pooled [CH];
    logic signed [DW-1:0]     pool_mem_q [N];

    // Reduce one 2x2 window: signed max, or floor average via a DW+2 sum.
    function automatic logic signed [DW-1:0] pool4(input logic [4*DW-1:0] w,
                                                   input logic avg);
        logic signed [DW-1:0] e [4];
        logic signed [DW-1:0] m;
        logic signed [DW+1:0] s;
        for (int j = 0; j < 4; j++) begin
            e[j] = w[j*DW +: DW];
        end
        m = e[0];
        s = '0;
        for (int j = 0; j < 4; j++) begin
            if (e[j] > m) begin
                m = e[j];
            end
            s = s + (DW+2)'(e[j]);
        end
        if (avg) begin
            s = s >>> 2;
            return s[DW-1:0];
        end
        return m;
    endfunction

    // Full-precision signed weight x feature product, sign-extended to ACC_W.
    function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [WW-1:0] a,
                                                         input logic signed [DW-1:0] b);
        logic signed [WW+DW-1:0] p;
        p = (WW+DW)'(a) * (WW+DW)'(b);
        return ACC_W'(p);
    endfunction

    // Pool every channel of the incoming window.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            pooled[c] = pool4(win_data[c*4*DW +: 4*DW], pool_mode);
        end
    end

    // Next-state and registered-output control.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        w_rd_d      = w_rd_q;
        w_addr_d    = w_addr_q;
        fc_done_d   = fc_done_q;
        clr_prob    = 1'b0;
        xfer        = win_valid && win_ready_q;
        pos_last    = (pos_q == PW'(PXY - 1));
        mac_last    = mac_en_q && (mac_idx_q == AW'(N - 1));
        case (state_q)
            S_FILL, S_DONE: begin
                if (xfer) begin
                    if (state_q == S_DONE) begin
                        clr_prob  = 1'b1;
                        fc_done_d = 1'b0;
                    end
                    if (pos_last) begin
                        state_d  = S_FC;
                        pos_d    = '0;
                        w_rd_d   = 1'b1;
                        w_addr_d = '0;
                    end else begin
                        state_d = S_FILL;
                        pos_d   = pos_q + 1'b1;
                    end
                end
            end
            S_FC: begin
                if (w_rd_q) begin
                    if (w_addr_q == AW'(N - 1)) begin
                        w_rd_d   = 1'b0;
                        w_addr_d = '0;
                    end else begin
                        w_addr_d = w_addr_q + 1'b1;
                    end
                end
                if (mac_last) begin
                    state_d   = S_DONE;
                    fc_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
        win_ready_d = (state_d != S_FC);
    end

    // Class accumulators: cleared on a new frame, MAC while weights return.
    always_comb begin
        prob_d = prob_q;
        if (clr_prob) begin
            prob_d = '0;
        end else if (mac_en_q) begin
            for (int k = 0; k < CLASSES; k++) begin
                prob_d[k*ACC_W +: ACC_W] = prob_q[k*ACC_W +: ACC_W]
                    + mac_term(w_data[k*WW +: WW], pool_mem_q[mac_idx_q]);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Control and result registers; MAC stage trails issue by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q       <= '0;
            w_rd_q      <= 1'b0;
            w_addr_q    <= '0;
            win_ready_q <= 1'b1;
            fc_done_q   <= 1'b0;
            prob_q      <= '0;
            mac_en_q    <= 1'b0;
            mac_idx_q   <= '0;
        end else begin
            pos_q       <= pos_d;
            w_rd_q      <= w_rd_d;
            w_addr_q    <= w_addr_d;
            win_ready_q <= win_ready_d;
            fc_done_q   <= fc_done_d;
            prob_q      <= prob_d;
            mac_en_q    <= w_rd_q;
            mac_idx_q   <= w_addr_q;
        end
    end

    // Feature buffer write: channel-major, then linear position.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int c = 0; c < CH; c++) begin
                pool_mem_q[AW'(c * PXY) + AW'(pos_q)] <= pooled[c];
            end
        end
    end

    assign win_ready = win_ready_q;
    assign w_rd      = w_rd_q;
    assign w_addr    = w_addr_q;
    assign fc_done   = fc_done_q;
    assign prob      = prob_q;

endmodule

// File: tb/tb_pool_fc_stream.sv
// Testbench for pool_fc_stream: directed and random frames against a
// behavioural model; a second instance with a 16-bit accumulator checks wrap.
module tb_pool_fc_stream;

    localparam int DW   = 8;
    localparam int CH   = 2;
    localparam int PX   = 2;
    localparam int PY   = 2;
    localparam int CL   = 3;
    localparam int WW   = 8;
    localparam int A24  = 24;
    localparam int A16  = 16;
    localparam int PXY  = PX * PY;
    localparam int N    = CH * PXY;
    localparam int AW   = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                pool_mode = 1'b0;
    logic                win_valid = 1'b0;
    logic [CH*4*DW-1:0]  win_data = '0;
    logic [CL*WW-1:0]    w_data;
    logic                win_ready, w_rd, fc_done;
    logic [AW-1:0]       w_addr;
    logic [CL*A24-1:0]   prob;
    logic                win_ready16, w_rd16, fc_done16;
    logic [AW-1:0]       w_addr16;
    logic [CL*A16-1:0]   prob16;

    int n_pass;
    int n_total;
    int m_feat [N];
    int m_pos;
    int wts [N][CL];
    int win_e [CH][4];

    pool_fc_stream #(.DW(DW), .CH(CH), .POOL_X(PX), .POOL_Y(PY), .CLASSES(CL),
                     .WW(WW), .ACC_W(A24)) dut (
        .clk(clk), .rst(rst), .pool_mode(pool_mode), .win_valid(win_valid),
        .win_ready(win_ready), .win_data(win_data), .w_rd(w_rd), .w_addr(w_addr),
        .w_data(w_data), .prob(prob), .fc_done(fc_done));

    pool_fc_stream #(.DW(DW), .CH(CH), .POOL_X(PX), .POOL_Y(PY), .CLASSES(CL),
                     .WW(WW), .ACC_W(A16)) dut16 (
        .clk(clk), .rst(rst), .pool_mode(pool_mode), .win_valid(win_valid),
        .win_ready(win_ready16), .win_data(win_data), .w_rd(w_rd16), .w_addr(w_addr16),
        .w_data(w_data), .prob(prob16), .fc_done(fc_done16));

    always #5 clk = ~clk;

    // Weight memory: data valid the cycle after a read, junk otherwise.
    always @(posedge clk) begin
        if (w_rd) begin
            for (int k = 0; k < CL; k++) begin
                w_data[k*WW +: WW] <= WW'(wts[w_addr][k]);
            end
        end else begin
            w_data <= (CL*WW)'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint p24(input int k);
        return longint'($signed(prob[k*A24 +: A24]));
    endfunction

    function automatic longint p16(input int k);
        return longint'($signed(prob16[k*A16 +: A16]));
    endfunction

    // Reference pooling from plain integer arithmetic.
    function automatic int ref_pool(input int c, input logic avg);
        int m;
        int s;
        m = win_e[c][0];
        s = 0;
        for (int j = 0; j < 4; j++) begin
            if (win_e[c][j] > m) m = win_e[c][j];
            s += win_e[c][j];
        end
        if (!avg) return m;
        return (s >= 0) ? s / 4 : -((-s + 3) / 4);
    endfunction

    // Reference score: dot product reduced modulo 2^accw, read back signed.
    function automatic longint exp_prob(input int k, input int accw);
        longint s;
        longint m;
        s = 0;
        for (int f = 0; f < N; f++) s += longint'(m_feat[f]) * longint'(wts[f][k]);
        m = longint'(1) << accw;
        s = s % m;
        if (s < 0) s += m;
        if (s >= m / 2) s -= m;
        return s;
    endfunction

    function automatic logic [CH*4*DW-1:0] pack_win();
        logic [CH*4*DW-1:0] v;
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < 4; j++)
                v[(c*4+j)*DW +: DW] = DW'(win_e[c][j]);
        return v;
    endfunction

    task automatic fill_win(input int v);
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < 4; j++) win_e[c][j] = v;
    endtask

    task automatic set_w(input int v);
        for (int f = 0; f < N; f++)
            for (int k = 0; k < CL; k++) wts[f][k] = v;
    endtask

    // Transfer the current win_e window and record it in the model.
    task automatic send(input logic mode);
        int g;
        g = 0;
        while (win_ready !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) begin
            n_total++;
            $error("FAIL ready_timeout: observed win_ready=%0b expected 1", win_ready);
        end
        win_data  = pack_win();
        pool_mode = mode;
        win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        for (int c = 0; c < CH; c++) m_feat[c*PXY + m_pos] = ref_pool(c, mode);
        m_pos = (m_pos + 1) % PXY;
    endtask

    // Called at #1 after the last-window edge: check issue trace and result.
    task automatic run_fc(input bit hold);
        if (hold) begin
            win_valid = 1'b1;
            win_data  = (CH*4*DW)'({$urandom, $urandom});
        end
        for (int i = 0; i < N; i++) begin
            chk("w_rd_issue", longint'(w_rd), 1);
            chk("w_addr_issue", longint'(w_addr), i);
            chk("w_addr16_issue", longint'(w_addr16), i);
            chk("win_ready_fc", longint'(win_ready), 0);
            if (i == 0) chk("fc_done_start", longint'(fc_done), 0);
            tick();
        end
        win_valid = 1'b0;
        chk("w_rd_end", longint'(w_rd), 0);
        chk("w_rd16_end", longint'(w_rd16), 0);
        chk("fc_done_early", longint'(fc_done), 0);
        tick();
        chk("fc_done", longint'(fc_done), 1);
        chk("fc_done16", longint'(fc_done16), 1);
        chk("win_ready_done", longint'(win_ready), 1);
        chk("win_ready16_done", longint'(win_ready16), 1);
        for (int k = 0; k < CL; k++) begin
            chk("prob_model", p24(k), exp_prob(k, A24));
            chk("prob16_model", p16(k), exp_prob(k, A16));
        end
    endtask

    task automatic frame_const(input int v, input int wv, input logic mode,
                               input bit hold, input bit chk_clr);
        fill_win(v);
        set_w(wv);
        for (int p = 0; p < PXY; p++) begin
            send(mode);
            if (p == 0 && chk_clr) begin
                chk("clear_fc_done", longint'(fc_done), 0);
                for (int k = 0; k < CL; k++) chk("clear_prob", p24(k), 0);
            end
        end
        run_fc(hold);
    endtask

    task automatic frame_rand();
        for (int f = 0; f < N; f++)
            for (int k = 0; k < CL; k++) wts[f][k] = int'($urandom_range(255)) - 128;
        for (int p = 0; p < PXY; p++) begin
            for (int c = 0; c < CH; c++)
                for (int j = 0; j < 4; j++) win_e[c][j] = int'($urandom_range(255)) - 128;
            send(1'($urandom_range(1)));
        end
        run_fc(1'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_pos   = 0;
        fill_win(0);
        set_w(0);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_win_ready", longint'(win_ready), 1);
        chk("rst_fc_done", longint'(fc_done), 0);
        chk("rst_w_rd", longint'(w_rd), 0);
        chk("rst_w_addr", longint'(w_addr), 0);
        for (int k = 0; k < CL; k++) chk("rst_prob", p24(k), 0);
        rst = 1'b0;

        // Max pool of a negative window at (0,0)
        set_w(0);
        wts[0][0] = 1;
        for (int p = 0; p < PXY; p++) begin
            fill_win(0);
            if (p == 0) begin
                win_e[0][0] = -5; win_e[0][1] = -3; win_e[0][2] = -7; win_e[0][3] = -4;
            end
            send(1'b0);
        end
        run_fc(1'b0);
        chk("s1_prob0", p24(0), -3);
        chk("s1_prob1", p24(1), 0);
        chk("s1_prob2", p24(2), 0);

        // Average pool, floor toward -inf, then a positive case
        set_w(0);
        wts[7][2] = 1;
        for (int p = 0; p < PXY; p++) begin
            fill_win(0);
            if (p == PXY - 1) begin
                win_e[1][0] = -1; win_e[1][1] = -2; win_e[1][2] = 0; win_e[1][3] = 0;
            end
            send(1'b1);
        end
        run_fc(1'b0);
        chk("s2_prob2_neg", p24(2), -1);
        for (int p = 0; p < PXY; p++) begin
            fill_win(0);
            if (p == PXY - 1) begin
                win_e[1][0] = 5; win_e[1][1] = 6; win_e[1][2] = 7; win_e[1][3] = 8;
            end
            send(1'b1);
        end
        run_fc(1'b0);
        chk("s2_prob2_pos", p24(2), 6);

        // Uniform frame, then with win_valid held through FC
        frame_const(3, -2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < CL; k++) chk("s3_prob", p24(k), -48);
        frame_const(3, -2, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < CL; k++) chk("s4_prob", p24(k), -48);

        // New frame from DONE clears result on its first transfer
        frame_const(1, 1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < CL; k++) chk("s5_prob", p24(k), 8);

        // Reset in the fourth FC cycle aborts the frame
        fill_win(3);
        set_w(-2);
        for (int p = 0; p < PXY; p++) send(1'b0);
        tick();
        tick();
        tick();
        chk("s6_w_addr", longint'(w_addr), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pos = 0;
        chk("s6_fc_done", longint'(fc_done), 0);
        chk("s6_win_ready", longint'(win_ready), 1);
        chk("s6_w_rd", longint'(w_rd), 0);
        for (int k = 0; k < CL; k++) chk("s6_prob", p24(k), 0);
        frame_const(3, -2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < CL; k++) chk("s6_refill_prob", p24(k), -48);

        // Random frames against the model
        for (int r = 0; r < 4; r++) frame_rand();

        // Accumulator wrap with a 16-bit accumulator
        frame_const(127, -128, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < CL; k++) begin
            chk("s7_prob16_wrap", p16(k), 1024);
            chk("s7_prob24", p24(k), -130048);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
